// File: rtl/wb_pkg.sv
// Shared constants for the writeback register file: default widths and
// the lane-merge mode encodings carried on wb_quarter.
package wb_pkg;

  localparam int WB_NUM_REGS = 16;
  localparam int WB_ADDR_W   = 4;
  localparam int WB_DATA_W   = 16;
  localparam int WB_CNT_W    = 16;

  // Lane-merge modes (H = upper half, L = lower half of the register)
  localparam logic [1:0] WB_Q_FULL = 2'b00;  // R <= D
  localparam logic [1:0] WB_Q_LOW  = 2'b01;  // L <= D[L]
  localparam logic [1:0] WB_Q_HIGH = 2'b10;  // H <= D[L]
  localparam logic [1:0] WB_Q_SEXT = 2'b11;  // R <= sext(D[L])

endpackage

// File: rtl/wb_lane_merge.sv
// Combinational lane merge: combines the current register value with the
// commit data according to the quarter mode. Shared by the commit path and
// the bypass path so both always agree.
module wb_lane_merge
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        quarter,
  output logic [DATA_W-1:0] new_val
);

  localparam int HW = DATA_W / 2;

  // Select which halves come from the old value and which from the data
  always_comb begin
    new_val = wr_data;
    case (quarter)
      WB_Q_FULL: new_val = wr_data;
      WB_Q_LOW:  new_val = {old_val[DATA_W-1:HW], wr_data[HW-1:0]};
      WB_Q_HIGH: new_val = {wr_data[HW-1:0], old_val[HW-1:0]};
      WB_Q_SEXT: new_val = {{HW{wr_data[HW-1]}}, wr_data[HW-1:0]};
      default:   new_val = wr_data;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-side register file: commits MEM/WB results into a 16-entry
// array with lane merging, supplies two combinational read ports, and
// counts committed writes. Register 0 is hardwired to zero.
// Optional feature: define WB_BYPASS_EN to forward the merged commit value
// to a read port addressing the register being written in the same cycle.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int NUM_REGS = WB_NUM_REGS,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DATA_W   = WB_DATA_W,
  parameter int CNT_W    = WB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_write,
  input  logic [1:0]        wb_quarter,
  input  logic [ADDR_W-1:0] wb_writeReg,
  input  logic [DATA_W-1:0] wb_writeData,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  wb_count
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]               cur_val;
  logic [DATA_W-1:0]               merged;
  logic                            commit;

  // Writes to r0 are dropped entirely, including the count increment
  assign commit  = wb_write && (wb_writeReg != '0);
  assign cur_val = regs[wb_writeReg];

  wb_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_val (cur_val),
    .wr_data (wb_writeData),
    .quarter (wb_quarter),
    .new_val (merged)
  );

  // Register array update; r0 is never written so it stays at its reset zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (commit) begin
      regs[wb_writeReg] <= merged;
    end
  end

  // Committed-write counter, wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (commit) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

`ifdef WB_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a = commit && (rd_addr_a == wb_writeReg);
  assign hit_b = commit && (rd_addr_b == wb_writeReg);

  // Read ports with same-cycle forwarding of the merged commit value
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (hit_a) rd_data_a = merged;
    if (hit_b) rd_data_b = merged;
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
  end
`else
  // Read ports return array contents only; decode stalls on WB hazards
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Expected values are
// hand-computed; the bypass scenario picks its expectation from
// WB_BYPASS_EN so the bench matches either build.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_write;
  logic [1:0]  wb_quarter;
  logic [3:0]  wb_writeReg;
  logic [15:0] wb_writeData;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [15:0] wb_count;

  int vecs;
  int miss;

  wb_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_write     (wb_write),
    .wb_quarter   (wb_quarter),
    .wb_writeReg  (wb_writeReg),
    .wb_writeData (wb_writeData),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one commit for one edge; returns 1ns after the edge with wb_write low
  task automatic commit(input logic [3:0] a, input logic [1:0] q, input logic [15:0] d);
    wb_write     = 1'b1;
    wb_writeReg  = a;
    wb_quarter   = q;
    wb_writeData = d;
    @(posedge clk); #1;
    wb_write     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      vecs++;
      if (rd_data_a !== 16'h0000) begin
        miss++; $display("FAIL reset_rd_a[%0d] got %h want 0000", i, rd_data_a);
      end
      vecs++;
      if (rd_data_b !== 16'h0000) begin
        miss++; $display("FAIL reset_rd_b[%0d] got %h want 0000", 15 - i, rd_data_b);
      end
    end
    vecs++;
    if (wb_count !== 16'h0000) begin
      miss++; $display("FAIL reset_count got %h want 0000", wb_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_merge();
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd3;
    commit(4'd3, 2'b00, 16'h1234);
    vecs++;
    if (rd_data_a !== 16'h1234) begin
      miss++; $display("FAIL merge_full got %h want 1234", rd_data_a);
    end
    commit(4'd3, 2'b01, 16'hEEAB);
    vecs++;
    if (rd_data_a !== 16'h12AB) begin
      miss++; $display("FAIL merge_low got %h want 12AB", rd_data_a);
    end
    commit(4'd3, 2'b10, 16'h77CD);
    vecs++;
    if (rd_data_b !== 16'hCDAB) begin
      miss++; $display("FAIL merge_high got %h want CDAB", rd_data_b);
    end
    vecs++;
    if (wb_count !== 16'd3) begin
      miss++; $display("FAIL merge_count got %h want 0003", wb_count);
    end
  endtask

  task automatic test_sext();
    rd_addr_a = 4'd5;
    commit(4'd5, 2'b11, 16'h0080);
    vecs++;
    if (rd_data_a !== 16'hFF80) begin
      miss++; $display("FAIL sext_neg got %h want FF80", rd_data_a);
    end
    commit(4'd5, 2'b11, 16'hAA7F);
    vecs++;
    if (rd_data_a !== 16'h007F) begin
      miss++; $display("FAIL sext_pos got %h want 007F", rd_data_a);
    end
    vecs++;
    if (wb_count !== 16'd5) begin
      miss++; $display("FAIL sext_count got %h want 0005", wb_count);
    end
  endtask

  task automatic test_r0();
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd3;
    commit(4'd0, 2'b00, 16'hFFFF);
    vecs++;
    if (rd_data_a !== 16'h0000) begin
      miss++; $display("FAIL r0_read got %h want 0000", rd_data_a);
    end
    vecs++;
    if (rd_data_b !== 16'hCDAB) begin
      miss++; $display("FAIL r0_other got %h want CDAB", rd_data_b);
    end
    vecs++;
    if (wb_count !== 16'd5) begin
      miss++; $display("FAIL r0_count got %h want 0005", wb_count);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_pre;
    commit(4'd7, 2'b00, 16'h1111);
    rd_addr_a    = 4'd7;
    rd_addr_b    = 4'd7;
    wb_write     = 1'b1;
    wb_writeReg  = 4'd7;
    wb_quarter   = 2'b00;
    wb_writeData = 16'h5555;
    #1;
`ifdef WB_BYPASS_EN
    exp_pre = 16'h5555;
`else
    exp_pre = 16'h1111;
`endif
    vecs++;
    if (rd_data_a !== exp_pre) begin
      miss++; $display("FAIL bypass_a got %h want %h", rd_data_a, exp_pre);
    end
    vecs++;
    if (rd_data_b !== exp_pre) begin
      miss++; $display("FAIL bypass_b got %h want %h", rd_data_b, exp_pre);
    end
    @(posedge clk); #1;
    wb_write = 1'b0;
    vecs++;
    if (rd_data_a !== 16'h5555 || rd_data_b !== 16'h5555) begin
      miss++; $display("FAIL bypass_post got %h/%h want 5555/5555", rd_data_a, rd_data_b);
    end
    // Partial-lane forward on A while B reads an unrelated register
    rd_addr_b    = 4'd3;
    wb_write     = 1'b1;
    wb_quarter   = 2'b01;
    wb_writeData = 16'h00AA;
    #1;
`ifdef WB_BYPASS_EN
    exp_pre = 16'h55AA;
`else
    exp_pre = 16'h5555;
`endif
    vecs++;
    if (rd_data_a !== exp_pre) begin
      miss++; $display("FAIL bypass_low got %h want %h", rd_data_a, exp_pre);
    end
    vecs++;
    if (rd_data_b !== 16'hCDAB) begin
      miss++; $display("FAIL bypass_nohit got %h want CDAB", rd_data_b);
    end
    @(posedge clk); #1;
    wb_write = 1'b0;
    vecs++;
    if (rd_data_a !== 16'h55AA) begin
      miss++; $display("FAIL bypass_low_post got %h want 55AA", rd_data_a);
    end
    vecs++;
    if (wb_count !== 16'd8) begin
      miss++; $display("FAIL bypass_count got %h want 0008", wb_count);
    end
  endtask

  task automatic test_async_reset();
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd5;
    #3;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
      miss++; $display("FAIL async_rst_rd got %h/%h want 0000/0000", rd_data_a, rd_data_b);
    end
    rd_addr_a = 4'd7;
    #1;
    vecs++;
    if (rd_data_a !== 16'h0000) begin
      miss++; $display("FAIL async_rst_r7 got %h want 0000", rd_data_a);
    end
    vecs++;
    if (wb_count !== 16'h0000) begin
      miss++; $display("FAIL async_rst_count got %h want 0000", wb_count);
    end
    // Release with a commit pending: it must land on the first live edge
    wb_write     = 1'b1;
    wb_writeReg  = 4'd9;
    wb_quarter   = 2'b00;
    wb_writeData = 16'h4321;
    rd_addr_a    = 4'd9;
    @(posedge clk); #6;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_write = 1'b0;
    vecs++;
    if (rd_data_a !== 16'h4321) begin
      miss++; $display("FAIL release_commit got %h want 4321", rd_data_a);
    end
    vecs++;
    if (wb_count !== 16'd1) begin
      miss++; $display("FAIL release_count got %h want 0001", wb_count);
    end
  endtask

  task automatic test_wrap();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wb_write    = 1'b1;
    wb_writeReg = 4'd1;
    wb_quarter  = 2'b00;
    for (int i = 0; i < 65535; i++) begin
      wb_writeData = 16'(i);
      @(posedge clk); #1;
    end
    wb_write = 1'b0;
    vecs++;
    if (wb_count !== 16'hFFFF) begin
      miss++; $display("FAIL wrap_full got %h want FFFF", wb_count);
    end
    commit(4'd1, 2'b00, 16'hBEEF);
    vecs++;
    if (wb_count !== 16'h0000) begin
      miss++; $display("FAIL wrap_zero got %h want 0000", wb_count);
    end
  endtask

  initial begin
    vecs         = 0;
    miss         = 0;
    rst_n        = 1'b0;
    wb_write     = 1'b0;
    wb_quarter   = 2'b00;
    wb_writeReg  = 4'd0;
    wb_writeData = 16'h0000;
    rd_addr_a    = 4'd0;
    rd_addr_b    = 4'd0;
    test_reset();
    test_merge();
    test_sext();
    test_r0();
    test_bypass();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
